// File: rtl/ifetch_buffer.sv
// ifetch_buffer: instruction fetch stage that issues imem requests and queues {pc, instr} pairs for decode.
// Define IFETCH_BYPASS_EN to forward a response to decode combinationally when the queue is empty.
module ifetch_buffer #(
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_advance,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            misalign
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [XLEN-1:0] r_fpc [DEPTH];
  logic [XLEN-1:0] r_fins [DEPTH];
  logic [XLEN-1:0] r_tag [MAX_OUTST];
  logic [PW-1:0]   r_wp, r_rp;
  logic [TW-1:0]   r_twp, r_trp;
  logic [CW-1:0]   r_count, r_outst, r_drop;
  logic w_credit, w_aligned, w_issue, w_rv, w_accept, w_empty, w_byp, w_pop, w_push;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTST - 1)) ? '0 : p + TW'(1);
  endfunction

  // Credit counts queued plus in-flight words so a returning response always has a slot.
  assign w_credit   = ((CW+1)'(r_count) + (CW+1)'(r_outst) < (CW+1)'(DEPTH)) && (r_outst < CW'(MAX_OUTST));
  assign w_aligned  = pc_in[1:0] == 2'b00;
  assign imem_req   = rst & w_credit & ~flush & w_aligned;
  assign misalign   = rst & w_credit & ~flush & ~w_aligned;
  assign imem_addr  = pc_in;
  assign w_issue    = imem_req & imem_gnt;
  assign pc_advance = w_issue;
  assign w_rv       = imem_rvalid & (r_outst != '0);
  assign w_accept   = w_rv & (r_drop == '0) & ~flush;
  assign w_empty    = r_count == '0;
`ifdef IFETCH_BYPASS_EN
  assign w_byp      = w_empty & w_accept;
`else
  assign w_byp      = 1'b0;
`endif
  assign id_valid   = ~w_empty | w_byp;
  assign id_pc      = w_byp ? r_tag[r_trp] : r_fpc[r_rp];
  assign id_instr   = w_byp ? imem_rdata : r_fins[r_rp];
  assign w_pop      = ~w_empty & id_ready & ~flush;
  assign w_push     = w_accept & ~(w_byp & id_ready);

  always_ff @(posedge clk) begin
    if (w_issue) r_tag[r_twp] <= pc_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_twp   <= '0;
      r_trp   <= '0;
      r_count <= '0;
      r_outst <= '0;
      r_drop  <= '0;
      r_fpc   <= '{default: '0};
      r_fins  <= '{default: '0};
    end else begin
      r_outst <= r_outst + CW'(w_issue) - CW'(w_rv);
      if (flush) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_twp   <= '0;
        r_trp   <= '0;
        r_count <= '0;
        r_drop  <= r_outst - CW'(w_rv);
      end else begin
        if (w_rv && r_drop != '0) r_drop <= r_drop - CW'(1);
        if (w_issue) r_twp <= tag_next(r_twp);
        if (w_accept) r_trp <= tag_next(r_trp);
        if (w_push) begin
          r_fpc[r_wp]  <= r_tag[r_trp];
          r_fins[r_wp] <= imem_rdata;
          r_wp         <= r_wp + PW'(1);
        end
        if (w_pop) r_rp <= r_rp + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk) disable iff (!rst) !(imem_rvalid && r_outst == '0))
    else $error("ifetch_buffer: imem_rvalid with no outstanding request");
`endif
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: random and directed stimulus checked every cycle against a queue-based fetch model.
module tb_ifetch_buffer;
  localparam int DEPTH = 4, MAX_OUTST = 2, XLEN = 32;

  logic clk = 1'b0, rst;
  logic [31:0] pc_in, imem_addr, imem_rdata, id_pc, id_instr;
  logic pc_advance, flush, imem_req, imem_gnt, imem_rvalid, id_valid, id_ready, misalign;

  always #5 clk = ~clk;

  ifetch_buffer #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_advance(pc_advance), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_instr(id_instr), .misalign(misalign)
  );

  typedef struct { logic [31:0] addr; int rdy; } req_t;
  req_t pend[$];
  logic [31:0] mq_pc[$], mq_in[$], tq[$];
  int outst, drop, cyc, n_tests, n_fail;
  int p_gnt, p_rv, p_rdy, p_flush, lat_max, mis_pct;
  logic force_flush;
  logic [31:0] pc, tgt;
  logic s_req, s_adv, s_mis, s_val;
  logic [31:0] s_addr, s_pc, s_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic drive();
    if (force_flush) flush = 1'b1;
    else begin
      flush = $urandom_range(99) < p_flush;
      if (flush) tgt = ($urandom_range(4095) << 2) | (($urandom_range(99) < mis_pct) ? 32'h2 : 32'h0);
    end
    pc_in       = pc;
    imem_gnt    = $urandom_range(99) < p_gnt;
    id_ready    = $urandom_range(99) < p_rdy;
    imem_rvalid = pend.size() > 0 && pend[0].rdy <= cyc && $urandom_range(99) < p_rv;
    imem_rdata  = imem_rvalid ? mem_word(pend[0].addr) : $urandom();
  endtask

  task automatic step();
    int fc;
    bit credit, e_req, e_mis, e_adv, rv, byp, e_val;
    logic [31:0] e_pc, e_ins, tagv;
    drive();
    @(negedge clk);
    s_req = imem_req; s_adv = pc_advance; s_mis = misalign; s_val = id_valid;
    s_addr = imem_addr; s_pc = id_pc; s_ins = id_instr;
    fc     = mq_pc.size();
    credit = (fc + outst < DEPTH) && (outst < MAX_OUTST);
    e_req  = credit && !flush && pc_in[1:0] == 2'b00;
    e_mis  = credit && !flush && pc_in[1:0] != 2'b00;
    e_adv  = e_req && imem_gnt;
    rv     = imem_rvalid && outst > 0;
    byp    = 1'b0;
`ifdef IFETCH_BYPASS_EN
    byp    = fc == 0 && drop == 0 && rv && !flush;
`endif
    e_val  = fc > 0 || byp;
    e_pc   = byp ? tq[0] : (fc > 0 ? mq_pc[0] : 32'h0);
    e_ins  = byp ? imem_rdata : (fc > 0 ? mq_in[0] : 32'h0);
    chk("imem_req", s_req, e_req);
    chk("misalign", s_mis, e_mis);
    chk("pc_advance", s_adv, e_adv);
    if (e_req) chk("imem_addr", s_addr, pc_in);
    chk("id_valid", s_val, e_val);
    if (e_val) begin
      chk("id_pc", s_pc, e_pc);
      chk("id_instr", s_ins, e_ins);
    end
    if (flush) begin
      mq_pc.delete(); mq_in.delete(); tq.delete();
      drop = outst - int'(rv);
    end else begin
      if (fc > 0 && id_ready) begin
        void'(mq_pc.pop_front());
        void'(mq_in.pop_front());
      end
      if (rv) begin
        if (drop > 0) drop--;
        else begin
          tagv = tq.pop_front();
          if (!(byp && id_ready)) begin
            mq_pc.push_back(tagv);
            mq_in.push_back(imem_rdata);
          end
        end
      end
      if (e_adv) tq.push_back(pc_in);
    end
    outst = outst + int'(e_adv) - int'(rv);
    if (imem_rvalid) void'(pend.pop_front());
    if (e_adv) pend.push_back(req_t'{addr: pc_in, rdy: cyc + 1 + int'($urandom_range(lat_max))});
    pc = flush ? tgt : (e_adv ? pc + 32'h4 : pc);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, k;
    bit found;
    n_tests = 0; n_fail = 0; outst = 0; drop = 0; cyc = 0;
    p_gnt = 0; p_rv = 0; p_rdy = 0; p_flush = 0; lat_max = 0; mis_pct = 0;
    force_flush = 1'b0; pc = 32'h0; tgt = 32'h0;
    rst = 1'b0; pc_in = '0; flush = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
    imem_rdata = '0; id_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc_advance", pc_advance, 0);
    chk("rst_misalign", misalign, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // first fetch: issue on first active cycle, decode sees it after rvalid
    p_gnt = 100; p_rv = 100; p_rdy = 100;
    step();
    chk("t1_adv", s_adv, 1);
    chk("t1_addr", s_addr, 32'h0);
    step();
`ifdef IFETCH_BYPASS_EN
    chk("t1_valid", s_val, 1);
    chk("t1_pc", s_pc, 32'h0);
    chk("t1_instr", s_ins, 32'h0050_0093);
`endif
    step();
`ifndef IFETCH_BYPASS_EN
    chk("t1_valid", s_val, 1);
    chk("t1_pc", s_pc, 32'h0);
    chk("t1_instr", s_ins, 32'h0050_0093);
`endif
    p_gnt = 0;
    repeat (6) step();

    // fill with decode stalled: exactly DEPTH issues, then drain in order
    force_flush = 1'b1; tgt = 32'h0; step(); force_flush = 1'b0;
    p_gnt = 100; p_rdy = 0; n = 0;
    repeat (10) begin step(); n += int'(s_adv); end
    chk("t2_issues", n, 4);
    chk("t2_req_low", s_req, 0);
    p_gnt = 0; p_rdy = 100; k = 0;
    repeat (8) begin
      step();
      if (s_val && k < 4) begin chk($sformatf("t2_pc%0d", k), s_pc, k * 4); k++; end
    end
    chk("t2_drained", k, 4);

    // grant held low: request stays up with a stable address
    force_flush = 1'b1; tgt = 32'h10; step(); force_flush = 1'b0;
    p_gnt = 0;
    repeat (3) begin
      step();
      chk("t3_req", s_req, 1);
      chk("t3_adv", s_adv, 0);
      chk("t3_addr", s_addr, 32'h10);
    end
    p_gnt = 100; step();
    chk("t3_adv_gnt", s_adv, 1);
    chk("t3_addr_gnt", s_addr, 32'h10);
    p_gnt = 0; repeat (4) step();

    // flush with two requests in flight
    p_rv = 0; p_gnt = 100;
    repeat (2) step();
    force_flush = 1'b1; tgt = 32'h100; step(); force_flush = 1'b0;
    chk("t4_flush_adv", s_adv, 0);
    p_rv = 100; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_val) begin found = 1'b1; chk("t4_first_pc", s_pc, 32'h100); end
    end
    chk("t4_seen", found, 1);
    p_gnt = 0; repeat (6) step();

    // flush coinciding with rvalid and a pop
    force_flush = 1'b1; tgt = 32'h200; step(); force_flush = 1'b0;
    p_rdy = 0; p_gnt = 100; p_rv = 0; step();
    p_rv = 100; step();
    p_rv = 0; step();
    force_flush = 1'b1; tgt = 32'h300; p_rv = 100; p_rdy = 100; p_gnt = 0; step(); force_flush = 1'b0;
    chk("t5_valid_at_flush", s_val, 1);
    step();
    chk("t5_empty", s_val, 0);
    n = 0;
    repeat (4) begin step(); n += int'(s_val); end
    chk("t5_dropped", n, 0);
    p_gnt = 100; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_val) begin found = 1'b1; chk("t5_first_pc", s_pc, 32'h300); end
    end
    chk("t5_seen", found, 1);
    p_gnt = 0; repeat (6) step();

    // misaligned target stalls until redirected
    force_flush = 1'b1; tgt = 32'h6; step(); force_flush = 1'b0;
    p_gnt = 100;
    repeat (3) begin
      step();
      chk("t6_mis", s_mis, 1);
      chk("t6_req", s_req, 0);
      chk("t6_adv", s_adv, 0);
    end
    force_flush = 1'b1; tgt = 32'h20; step(); force_flush = 1'b0;
    chk("t6_mis_flush", s_mis, 0);
    step();
    chk("t6_req_new", s_req, 1);
    chk("t6_addr_new", s_addr, 32'h20);

    mis_pct = 10;
    for (int seg = 0; seg < 30; seg++) begin
      p_gnt = $urandom_range(100, 20); p_rv = $urandom_range(100, 20);
      p_rdy = $urandom_range(100, 0); p_flush = $urandom_range(8, 0);
      lat_max = $urandom_range(4, 0);
      repeat (100) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
